// File: rtl/pong_state_poller.sv
// Polls a stepped pong game: for each of four slots it drives a select, pulses the
// game step clock, waits for the output to settle and captures it; the four bytes
// are then published together with a one-cycle frame_valid.
module pong_state_poller #(
    parameter int STEP_HIGH = 2,
    parameter int SETTLE    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       auto_poll,
    input  logic       left_cmd,
    input  logic       right_cmd,
    input  logic       game_reset,
    output logic [7:0] game_ui,
    input  logic [7:0] game_uo,
    output logic [7:0] ball_x,
    output logic [7:0] ball_y,
    output logic [7:0] left_y,
    output logic [7:0] right_y,
    output logic       frame_valid,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, CAPT, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] HIGH_LAST   = 4'(STEP_HIGH - 1);

    state_t     state;
    logic [1:0] slot;
    logic [3:0] cnt;
    // Slot 3 never needs a holding register: it is published straight from game_uo.
    logic [7:0] cap0, cap1, cap2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            slot        <= 2'd0;
            cnt         <= 4'd0;
            game_ui     <= 8'h00;
            cap0        <= 8'h00;
            cap1        <= 8'h00;
            cap2        <= 8'h00;
            ball_x      <= 8'h00;
            ball_y      <= 8'h00;
            left_y      <= 8'h00;
            right_y     <= 8'h00;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start || auto_poll) begin
                        state   <= SETUP;
                        slot    <= 2'd0;
                        cnt     <= 4'd0;
                        game_ui <= {5'b00000, game_reset, right_cmd, left_cmd};
                        busy    <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == SETTLE_LAST) begin
                        state      <= HIGH;
                        cnt        <= 4'd0;
                        game_ui[5] <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (cnt == HIGH_LAST) begin
                        state      <= CAPT;
                        cnt        <= 4'd0;
                        game_ui[5] <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CAPT: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt <= 4'd0;
                        case (slot)
                            2'd0:    cap0 <= game_uo;
                            2'd1:    cap1 <= game_uo;
                            2'd2:    cap2 <= game_uo;
                            default: ;
                        endcase
                        if (slot == 2'd3) begin
                            state       <= DONE;
                            ball_x      <= cap0;
                            ball_y      <= cap1;
                            left_y      <= cap2;
                            right_y     <= game_uo;
                            frame_valid <= 1'b1;
                        end else begin
                            state        <= SETUP;
                            slot         <= slot + 2'd1;
                            game_ui[4:3] <= slot + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    frame_valid <= 1'b0;
                    busy        <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_state_poller.sv
// Bench for pong_state_poller: table-driven frames, hand-written corner sequences,
// and a randomized auto-poll run checked against frame timing computed from the rules.
module tb_pong_state_poller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, auto_poll, left_cmd, right_cmd, game_reset;
    logic [7:0] game_ui, ball_x, ball_y, left_y, right_y;
    logic [7:0] game_uo = 8'h00;
    logic       frame_valid, busy;

    logic       start_s;
    logic [7:0] ui_s, bx_s, by_s, ly_s, ry_s;
    logic [7:0] uo_s = 8'h00;
    logic       fv_s, busy_s;

    pong_state_poller u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .auto_poll(auto_poll),
        .left_cmd(left_cmd), .right_cmd(right_cmd), .game_reset(game_reset),
        .game_ui(game_ui), .game_uo(game_uo),
        .ball_x(ball_x), .ball_y(ball_y), .left_y(left_y), .right_y(right_y),
        .frame_valid(frame_valid), .busy(busy)
    );

    pong_state_poller #(.STEP_HIGH(1), .SETTLE(1)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .auto_poll(1'b0),
        .left_cmd(1'b0), .right_cmd(1'b0), .game_reset(1'b0),
        .game_ui(ui_s), .game_uo(uo_s),
        .ball_x(bx_s), .ball_y(by_s), .left_y(ly_s), .right_y(ry_s),
        .frame_valid(fv_s), .busy(busy_s)
    );

    // Game models: on each step edge, present the byte for the selected slot.
    logic [7:0] gval [4];
    logic [7:0] gval_s [4];
    always @(posedge game_ui[5]) game_uo <= gval[game_ui[4:3]];
    always @(posedge ui_s[5])    uo_s    <= gval_s[ui_s[4:3]];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int frame_lat(input int settle, input int step_high);
        return 1 + 4 * (2 * settle + step_high);
    endfunction

    task automatic run_frame(input logic l, input logic r, input logic g, input logic drop,
                             input logic [31:0] vals, input logic [2:0] exp_cmd, input string tag);
        int cyc, lat, edges, cmd_bad, sel_bad, top_bad, busy_bad;
        logic prev5;
        logic [1:0] prev_sel;
        logic [7:0] sels;
        gval[0] = vals[31:24]; gval[1] = vals[23:16]; gval[2] = vals[15:8]; gval[3] = vals[7:0];
        @(negedge clk);
        left_cmd = l; right_cmd = r; game_reset = g; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (drop) begin left_cmd = 1'b0; right_cmd = 1'b0; game_reset = 1'b0; end
        cyc = 1; lat = 0; edges = 0; cmd_bad = 0; sel_bad = 0; top_bad = 0; busy_bad = 0;
        prev5 = 1'b0; prev_sel = 2'd0; sels = 8'h00;
        while (lat == 0 && cyc < 100) begin
            if (game_ui[2:0] !== exp_cmd) cmd_bad++;
            if (game_ui[7:6] !== 2'b00) top_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (game_ui[5] && !prev5) begin
                if (edges < 4) sels[edges*2 +: 2] = game_ui[4:3];
                edges++;
            end
            if (game_ui[5] && prev5 && game_ui[4:3] !== prev_sel) sel_bad++;
            if (frame_valid) lat = cyc;
            prev5 = game_ui[5];
            prev_sel = game_ui[4:3];
            if (lat == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_latency"}, lat, frame_lat(2, 2));
        check({tag, "_step_edges"}, edges, 4);
        check({tag, "_select_order"}, sels, 8'b11_10_01_00);
        check({tag, "_select_stable"}, sel_bad, 0);
        check({tag, "_cmd_held"}, cmd_bad, 0);
        check({tag, "_ui_top_zero"}, top_bad, 0);
        check({tag, "_busy_during"}, busy_bad, 0);
        check({tag, "_outputs"}, {ball_x, ball_y, left_y, right_y}, vals);
        @(negedge clk);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_fv_one_cycle"}, frame_valid, 0);
        check({tag, "_cmd_after"}, game_ui[2:0], exp_cmd);
    endtask

    typedef struct packed {
        logic        l, r, g, drop;
        logic [31:0] vals;
        logic [2:0]  exp_cmd;
    } vec_t;

    initial begin
        vec_t tbl [4];
        int   n, fvcount, badtime, busy_bad, lat;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h11223344, 3'b000};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hA55A01FE, 3'b101};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h3CC37788, 3'b000};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hFF00807F, 3'b010};

        rst_n = 1'b0; start = 1'b0; auto_poll = 1'b0; start_s = 1'b0;
        left_cmd = 1'b0; right_cmd = 1'b0; game_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin gval[i] = 8'h00; gval_s[i] = 8'h00; end

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_game_ui", game_ui, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_outputs", {ball_x, ball_y, left_y, right_y}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort during HIGH of slot 2
        gval[0] = 8'h11; gval[1] = 8'h22; gval[2] = 8'h33; gval[3] = 8'h44;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(game_ui[5] && game_ui[4:3] == 2'd2) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_slot2_high", n < 60, 1);
        rst_n = 1'b0;
        #1;
        check("abort_game_ui", game_ui, 0);
        check("abort_busy", busy, 0);
        check("abort_outputs", {ball_x, ball_y, left_y, right_y}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fvcount = 0; busy_bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (frame_valid) fvcount++;
            if (busy) busy_bad++;
        end
        check("abort_no_frame", fvcount, 0);
        check("abort_stays_idle", busy_bad, 0);
        check("abort_outputs_after", {ball_x, ball_y, left_y, right_y}, 0);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 32'h11223344, 3'b000, "post_abort");

        // Table-driven frames
        foreach (tbl[i]) begin
            run_frame(tbl[i].l, tbl[i].r, tbl[i].g, tbl[i].drop, tbl[i].vals, tbl[i].exp_cmd,
                      $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Auto poll with random start noise: frames every 26 cycles, nothing extra
        for (int i = 0; i < 4; i++) gval[i] = 8'($urandom);
        @(negedge clk);
        auto_poll = 1'b1;
        fvcount = 0; badtime = 0;
        for (int c = 1; c <= 77; c++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            if (frame_valid !== ((c >= 25 && (c - 25) % 26 == 0) ? 1'b1 : 1'b0)) badtime++;
            if (frame_valid) fvcount++;
            if (c == 77) begin auto_poll = 1'b0; start = 1'b0; end
        end
        check("auto_pulse_timing", badtime, 0);
        check("auto_pulse_count", fvcount, 3);
        check("auto_outputs", {ball_x, ball_y, left_y, right_y},
              {gval[0], gval[1], gval[2], gval[3]});
        fvcount = 0; busy_bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (frame_valid) fvcount++;
            if (busy) busy_bad++;
        end
        check("auto_stop_no_frame", fvcount, 0);
        check("auto_stop_idle", busy_bad, 0);

        // Minimum timing parameters
        gval_s[0] = 8'hFF; gval_s[1] = 8'h00; gval_s[2] = 8'h80; gval_s[3] = 8'h7F;
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        lat = 0; n = 1;
        while (lat == 0 && n < 60) begin
            if (fv_s) lat = n;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("small_latency", lat, frame_lat(1, 1));
        check("small_outputs", {bx_s, by_s, ly_s, ry_s}, 32'hFF00807F);
        @(negedge clk);
        check("small_busy_after", busy_s, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_state_poller.md
PONG_STATE_POLLER -- requirements
Module: pong_state_poller

Interface
REQ-001 Parameter STEP_HIGH, default 2: cycles the game step clock is held high per slot (legal 1..15).
REQ-002 Parameter SETTLE, default 2: cycles of setup before each step edge and cycles of wait after it (legal 1..15).
REQ-003 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request one poll frame; sampled in IDLE only.
REQ-006 auto_poll  input  1  when high, a new frame starts from IDLE without start.
REQ-007 left_cmd  input  1  left paddle command, forwarded to the game.
REQ-008 right_cmd  input  1  right paddle command, forwarded to the game.
REQ-009 game_reset  input  1  game reset request, forwarded to the game.
REQ-010 game_ui  output  8  drives the game input byte: [0] left cmd, [1] right cmd, [2] game reset, [4:3] select, [5] step clock, [7:6] zero.
REQ-011 game_uo  input  8  game output byte; holds the value the game selected at its most recent step edge.
REQ-012 ball_x, ball_y, left_y, right_y  output  8 each  last complete captured frame.
REQ-013 frame_valid  output  1  one-cycle pulse when the four state outputs update.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, SETUP, HIGH, CAPT and DONE, with a 2-bit slot index (0..3) and a 4-bit cycle counter.
REQ-016 IDLE -> SETUP, with slot = 0, on a clock edge where start | auto_poll is high.
- On that same edge, left_cmd, right_cmd and game_reset are latched into game_ui[2:0].
- These bits are held unchanged until the next frame is accepted.
REQ-017 SETUP lasts SETTLE cycles.
- game_ui[4:3] = slot; game_ui[5] = 0.
REQ-018 HIGH lasts STEP_HIGH cycles.
- game_ui[5] = 1; game_ui[4:3] = slot (unchanged).
REQ-019 CAPT lasts SETTLE cycles.
- game_ui[5] = 0; game_ui[4:3] = slot.
- On the edge leaving CAPT, game_uo is stored in capture register [slot].
REQ-020 Slot-to-register mapping: 0 -> ball_x, 1 -> ball_y, 2 -> left_y, 3 -> right_y.
REQ-021 Leaving CAPT with slot < 3: go to SETUP with slot + 1. Leaving CAPT with slot = 3: go to DONE.
REQ-022 On the edge entering DONE, all four capture registers are copied to the outputs atomically, with slot 3 taken directly from game_uo.
REQ-023 DONE lasts one cycle with frame_valid = 1, then returns to IDLE.
- When auto_poll is high, the frame after DONE starts on the IDLE edge, so there is exactly one idle cycle between frames.
REQ-024 Latency: frame_valid is high in cycle 1 + 4*(2*SETTLE + STEP_HIGH) after the accepting edge, which is cycle 25 at the defaults.
REQ-025 Exactly four rising edges of game_ui[5] occur per frame, one per slot; game_ui[5] never toggles outside HIGH.
REQ-026 start pulses during busy are ignored and never queued; a start coincident with DONE is also ignored.
REQ-027 game_ui[4:3] changes only on the SETUP entry edge, never while game_ui[5] = 1.
REQ-028 Each captured byte reflects a different game tick; the block makes no claim of single-tick coherence across the four values.
REQ-029 The cycle counter reload and compare SHALL use counter = N-1 terminal values; the counter does not wrap within a state.

Reset
REQ-030 When rst_n is low, the block SHALL asynchronously force the following, including mid-frame:
- FSM to IDLE; slot and counter to 0.
- game_ui to 8'h00.
- ball_x, ball_y, left_y, right_y and the capture registers to 8'h00.
- frame_valid = 0 and busy = 0.
REQ-031 After rst_n deasserts, the first frame is accepted no earlier than the first clock edge at which rst_n is high.
REQ-032 An aborted frame produces no frame_valid and leaves the outputs at 0.

Verification
REQ-033 Single frame: the game model returns 8'h11/22/33/44 per slot; pulse start with defaults -> frame_valid in cycle 25, outputs ball_x=11 ball_y=22 left_y=33 right_y=44, busy low afterwards.
REQ-034 Edge count: over one frame, count game_ui[5] rising edges -> exactly 4.
- Select at each edge is 0, 1, 2, 3 in order.
- game_ui[4:3] is stable while game_ui[5] = 1.
REQ-035 Command latch: left_cmd=1, game_reset=1 at start, dropped to 0 on the next cycle -> game_ui[2:0]=3'b101 for the whole frame; the next frame with inputs at 0 gives 3'b000.
REQ-036 Auto/ignore: auto_poll=1 for three frames with start toggling randomly -> frame_valid pulses exactly 26 cycles apart, with no extra frames.
REQ-037 Reset mid-frame: assert rst_n low during HIGH of slot 2 -> game_ui=00, busy=0, outputs stay 00 immediately; after release and a start, a clean 25-cycle frame follows.
REQ-038 Parameters: STEP_HIGH=1, SETTLE=1 -> frame_valid in cycle 13, with correct capture of 8'hFF/00/80/7F.
